time_unit_counter: RTL and testbench
====================================

Name: time_unit_counter

Overview:
- Parametrised successor to the hour counter. One block serves seconds, minutes, hours, days and months.
- It is a fully synchronous counter advanced by a `tick` enable from the lower unit's carry. No clock muxing.
- Set mode adds up/down adjustment with auto-repeat, a parallel load, and a borrow output.
- It produces registered 12/24-hour display values as two BCD digits with a PM flag, which feed the existing bcd_to_7segment decoders.

Parameters:
- MODULO, 24, number of distinct counter values (2..99).
- BITS, 5, counter width; must satisfy 2^BITS >= MIN_VALUE+MODULO.
- MIN_VALUE, 0, lowest count value: 0 for time units, 1 for day/month. Legal range is MIN_VALUE..MIN_VALUE+MODULO-1, which must be <= 99.
- AMPM_EN, 0, 1 enables 12-hour conversion; legal only with MODULO=24 and MIN_VALUE=0.
- REPEAT_DELAY, 50_000_000, clock cycles a button is held before auto-repeat starts.
- REPEAT_RATE, 10_000_000, clock cycles between auto-repeat steps.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- tick  in  1  single-cycle count enable (lower unit carry or 1 Hz strobe).
- set  in  1  1 = set mode (SW[0]).
- up_btn  in  1  raw increment button, active-high, asynchronous.
- down_btn  in  1  raw decrement button, active-high, asynchronous.
- load  in  1  single-cycle parallel load strobe.
- load_value  in  BITS  value to load.
- mode_ampm  in  1  1 = 12-hour display (SW[3]); ignored when AMPM_EN=0.
- count  out  BITS  current binary count.
- bcd_tens  out  4  display tens digit.
- bcd_ones  out  4  display ones digit.
- pm  out  1  1 when count >= 12 (AMPM_EN=1 only; otherwise 0).
- carry  out  1  one-cycle pulse on run-mode wrap.
- borrow  out  1  one-cycle pulse on set-mode decrement wrap (used for downward rollover of linked units).

Behaviour:
- Reset (async, any time): count=MIN_VALUE, carry=0, borrow=0, pm=0, bcd_tens/bcd_ones = BCD of MIN_VALUE, repeat counters cleared. No pulses are emitted on reset release.
- Priority each clock edge: load > set-mode step > run-mode tick.
- load:
  - count <= load_value if it is in the legal range; otherwise count <= MIN_VALUE.
  - No carry or borrow.
- Run mode (set=0), tick=1:
  - count <= count+1.
  - At MIN_VALUE+MODULO-1, count wraps to MIN_VALUE and carry=1 in the following cycle only.
  - Button inputs are ignored in run mode; repeat state is held cleared.
- Set mode (set=1): tick is ignored and carry stays 0.
- Each button path:
  - 2-FF synchroniser, then rising-edge detection, producing one step on the press edge.
  - If held, a further step after REPEAT_DELAY cycles, then one step every REPEAT_RATE cycles until release.
  - Release clears the repeat counter.
- Up step: count+1, wrapping max->MIN_VALUE with no carry.
- Down step: count-1, wrapping MIN_VALUE->max with borrow=1 for one cycle.
- Both buttons stepping in the same cycle: no change.
- Leaving set mode mid-hold: repeat state is cleared immediately. Re-entering set mode with a button already held does not step until release and re-press (the edge detector sees the synchronised level as prior state).
- Display path (1-cycle latency from count; mode_ampm is sampled each clock):
  - When AMPM_EN=0 or mode_ampm=0: disp = count.
  - When 12-hour display is active:
    - count 0 -> 12, pm=0.
    - count 1..11 -> count, pm=0.
    - count 12 -> 12, pm=1.
    - count 13..23 -> count-12, pm=1.
  - bcd_tens = disp/10 and bcd_ones = disp%10, registered in the same cycle as disp. The division may be implemented as a compare-subtract chain; no multi-cycle converter is used.
- All outputs are registered; no combinational path from any input to any output.

Decomposition:
- Shared package time_pkg:
  - HALF_DAY=12.
  - BCD digit width 4.
  - Default REPEAT_DELAY/REPEAT_RATE for a 50 MHz board.
  - Function to_bcd2 (0..99 -> {tens, ones}).
- Sub-module button_repeat (synchroniser, edge detect, auto-repeat), instantiated twice with parameters REPEAT_DELAY and REPEAT_RATE.
  - Ports: clock, reset, enable, btn, step.

Test Plan:
- Reset mid-count (count=17, AMPM_EN=1, mode_ampm=1): assert reset -> count=0, bcd=1,2 after the next clock, pm=0, carry=0 throughout.
- MODULO=60: 59 ticks from 0 -> count=59, carry=0. 60th tick -> count=0 and carry=1 for exactly one cycle. A tick on the following cycle gives count=1 with no carry.
- Set mode, MODULO=24: at count=0, a down press -> count=23 and borrow pulses once. Holding up for REPEAT_DELAY+3*REPEAT_RATE cycles -> exactly 5 increments total; ticks during this period have no effect.
- MIN_VALUE=1, MODULO=12: tick at 12 -> 1 with carry. load_value=0 -> count=1. load_value=7 together with an up step -> count=7.
- 12-hour mapping sweep: count 0, 11, 12, 13, 23 -> (tens, ones, pm) = (1,2,0), (1,1,0), (1,2,1), (0,1,1), (1,1,1), each one cycle after count. Toggling mode_ampm at 23 gives 2,3 on the next cycle.
- Both buttons pressed on the same edge -> no change. Set dropped mid-hold with up held, then raised again -> no step until release and re-press.

Source files
------------

// File: rtl/time_pkg.sv
// Shared constants and helpers for the clock/calendar time-unit counters.
// to_bcd2 uses a compare-subtract chain so it stays single-cycle combinational.
package time_pkg;

  localparam int HALF_DAY = 12;
  localparam int BCD_W = 4;
  localparam int DEFAULT_REPEAT_DELAY = 50_000_000;
  localparam int DEFAULT_REPEAT_RATE = 10_000_000;

  typedef enum logic [1:0] {
    STEP_NONE,
    STEP_UP,
    STEP_DOWN
  } step_dir_e;

  function automatic logic [2*BCD_W-1:0] to_bcd2(input logic [6:0] value);
    logic [6:0] rem;
    logic [BCD_W-1:0] tens;
    rem = value;
    tens = '0;
    for (int i = 0; i < 9; i++) begin
      if (rem >= 7'd10) begin
        rem = rem - 7'd10;
        tens = tens + 4'd1;
      end
    end
    return {tens, 4'(rem)};
  endfunction

endpackage

// File: rtl/time_unit_counter_if.sv
// Control/status bundle of one time-unit counter: count enables and set-mode
// inputs toward the counter, binary and BCD display values back.
interface time_unit_counter_if #(
  parameter int BITS = 5
);
  import time_pkg::*;

  logic tick;
  logic set;
  logic up_btn;
  logic down_btn;
  logic load;
  logic [BITS-1:0] load_value;
  logic mode_ampm;
  logic [BITS-1:0] count;
  logic [BCD_W-1:0] bcd_tens;
  logic [BCD_W-1:0] bcd_ones;
  logic pm;
  logic carry;
  logic borrow;

  modport master (
    output tick, set, up_btn, down_btn, load, load_value, mode_ampm,
    input  count, bcd_tens, bcd_ones, pm, carry, borrow
  );

  modport slave (
    input  tick, set, up_btn, down_btn, load, load_value, mode_ampm,
    output count, bcd_tens, bcd_ones, pm, carry, borrow
  );

endinterface

// File: rtl/button_repeat.sv
// Raw push-button to step pulses: 2-FF synchroniser, press-edge step, then
// auto-repeat after a hold delay at a fixed rate. Disable clears repeat state.
module button_repeat
  import time_pkg::*;
#(
  parameter int REPEAT_DELAY = DEFAULT_REPEAT_DELAY,
  parameter int REPEAT_RATE  = DEFAULT_REPEAT_RATE
) (
  input  logic clock,
  input  logic reset,
  input  logic enable,
  input  logic btn,
  output logic step
);

  localparam int MAX_CYC = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int CW = $clog2(MAX_CYC + 1);
  localparam logic [CW-1:0] DELAY_LOAD = CW'(REPEAT_DELAY - 1);
  localparam logic [CW-1:0] RATE_LOAD  = CW'(REPEAT_RATE - 1);

  logic sync1, sync2, prev;
  logic active;
  logic [CW-1:0] rpt_cnt;
  logic press;

  // prev keeps tracking while disabled, so a button already held on enable
  // is not mistaken for a fresh press
  assign press = sync2 & ~prev;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      prev    <= 1'b0;
      active  <= 1'b0;
      rpt_cnt <= '0;
      step    <= 1'b0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
      prev  <= sync2;
      step  <= 1'b0;
      if (!enable || !sync2) begin
        active  <= 1'b0;
        rpt_cnt <= '0;
      end else if (press) begin
        step    <= 1'b1;
        active  <= 1'b1;
        rpt_cnt <= DELAY_LOAD;
      end else if (active) begin
        if (rpt_cnt == '0) begin
          step    <= 1'b1;
          rpt_cnt <= RATE_LOAD;
        end else begin
          rpt_cnt <= rpt_cnt - 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/time_unit_counter.sv
// Generic wrapping time-unit counter (sec/min/hour/day/month) with set-mode
// up/down buttons, parallel load, carry/borrow and registered BCD display.
module time_unit_counter
  import time_pkg::*;
#(
  parameter int MODULO       = 24,
  parameter int BITS         = 5,
  parameter int MIN_VALUE    = 0,
  parameter int AMPM_EN      = 0,
  parameter int REPEAT_DELAY = DEFAULT_REPEAT_DELAY,
  parameter int REPEAT_RATE  = DEFAULT_REPEAT_RATE
) (
  input logic clock,
  input logic reset,
  time_unit_counter_if.slave bus
);

  localparam int MAX_VALUE = MIN_VALUE + MODULO - 1;
  localparam logic [BITS-1:0] MIN_C = BITS'(MIN_VALUE);
  localparam logic [BITS-1:0] MAX_C = BITS'(MAX_VALUE);
  localparam logic [2*BCD_W-1:0] RESET_BCD = to_bcd2(7'(MIN_VALUE));

  logic up_step, down_step;
  step_dir_e dir;
  logic load_ok;
  logic [BITS-1:0] count_q;
  logic carry_q, borrow_q, pm_q;
  logic [2*BCD_W-1:0] bcd_q, bcd_d;
  logic [6:0] cnt7, disp;
  logic pm_d;

  button_repeat #(.REPEAT_DELAY(REPEAT_DELAY), .REPEAT_RATE(REPEAT_RATE)) u_up (
    .clock (clock),
    .reset (reset),
    .enable(bus.set),
    .btn   (bus.up_btn),
    .step  (up_step)
  );

  button_repeat #(.REPEAT_DELAY(REPEAT_DELAY), .REPEAT_RATE(REPEAT_RATE)) u_down (
    .clock (clock),
    .reset (reset),
    .enable(bus.set),
    .btn   (bus.down_btn),
    .step  (down_step)
  );

  // simultaneous up and down steps cancel
  always_comb begin
    dir = STEP_NONE;
    if (up_step && !down_step) dir = STEP_UP;
    else if (down_step && !up_step) dir = STEP_DOWN;
  end

  assign load_ok = (int'(bus.load_value) >= MIN_VALUE) && (int'(bus.load_value) <= MAX_VALUE);

  always_comb begin
    cnt7 = 7'(count_q);
    disp = cnt7;
    pm_d = 1'b0;
    if (AMPM_EN != 0 && bus.mode_ampm) begin
      pm_d = (cnt7 >= 7'(HALF_DAY));
      if (cnt7 == 7'd0) disp = 7'(HALF_DAY);
      else if (cnt7 > 7'(HALF_DAY)) disp = cnt7 - 7'(HALF_DAY);
    end
    bcd_d = to_bcd2(disp);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count_q  <= MIN_C;
      carry_q  <= 1'b0;
      borrow_q <= 1'b0;
      pm_q     <= 1'b0;
      bcd_q    <= RESET_BCD;
    end else begin
      carry_q  <= 1'b0;
      borrow_q <= 1'b0;
      if (bus.load) begin
        count_q <= load_ok ? bus.load_value : MIN_C;
      end else if (bus.set) begin
        case (dir)
          STEP_UP: count_q <= (count_q == MAX_C) ? MIN_C : count_q + 1'b1;
          STEP_DOWN: begin
            if (count_q == MIN_C) begin
              count_q  <= MAX_C;
              borrow_q <= 1'b1;
            end else begin
              count_q <= count_q - 1'b1;
            end
          end
          default: ;
        endcase
      end else if (bus.tick) begin
        if (count_q == MAX_C) begin
          count_q <= MIN_C;
          carry_q <= 1'b1;
        end else begin
          count_q <= count_q + 1'b1;
        end
      end
      pm_q  <= pm_d;
      bcd_q <= bcd_d;
    end
  end

  assign bus.count    = count_q;
  assign bus.carry    = carry_q;
  assign bus.borrow   = borrow_q;
  assign bus.pm       = pm_q;
  assign bus.bcd_tens = bcd_q[2*BCD_W-1:BCD_W];
  assign bus.bcd_ones = bcd_q[BCD_W-1:0];

endmodule

// File: tb/tb_time_unit_counter.sv
// Directed bench for time_unit_counter: hour (12/24h), minute and month
// configurations sharing one clock and reset.
module tb_time_unit_counter;

  localparam int RD = 20;
  localparam int RR = 8;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int errors = 0;
  int checks = 0;

  always #5 clock = ~clock;

  time_unit_counter_if #(.BITS(5)) b24 ();
  time_unit_counter_if #(.BITS(6)) b60 ();
  time_unit_counter_if #(.BITS(4)) b12 ();

  time_unit_counter #(.MODULO(24), .BITS(5), .MIN_VALUE(0), .AMPM_EN(1),
    .REPEAT_DELAY(RD), .REPEAT_RATE(RR)) u24 (.clock(clock), .reset(reset), .bus(b24));
  time_unit_counter #(.MODULO(60), .BITS(6), .MIN_VALUE(0), .AMPM_EN(0),
    .REPEAT_DELAY(RD), .REPEAT_RATE(RR)) u60 (.clock(clock), .reset(reset), .bus(b60));
  time_unit_counter #(.MODULO(12), .BITS(4), .MIN_VALUE(1), .AMPM_EN(0),
    .REPEAT_DELAY(RD), .REPEAT_RATE(RR)) u12 (.clock(clock), .reset(reset), .bus(b12));

  task automatic clk1();
    @(posedge clock);
    #1;
  endtask

  task automatic load24(input int v);
    b24.load = 1'b1;
    b24.load_value = 5'(v);
    clk1();
    b24.load = 1'b0;
  endtask

  task automatic load12(input int v);
    b12.load = 1'b1;
    b12.load_value = 4'(v);
    clk1();
    b12.load = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) clk1();
    reset = 1'b0;
    clk1();
    checks++; if (b60.count !== 6'd0 || b60.carry !== 1'b0) begin errors++;
      $display("FAIL init60: count=%0d carry=%0d expected 0/0", b60.count, b60.carry); end
    checks++; if (b12.count !== 4'd1 || b12.bcd_tens !== 4'd0 || b12.bcd_ones !== 4'd1) begin errors++;
      $display("FAIL init12: count=%0d bcd=%0d%0d expected 1/01", b12.count, b12.bcd_tens, b12.bcd_ones); end
    b24.mode_ampm = 1'b1;
    load24(17);
    checks++; if (b24.count !== 5'd17) begin errors++;
      $display("FAIL load17: count=%0d expected 17", b24.count); end
    clk1();
    checks++; if (b24.bcd_tens !== 4'd0 || b24.bcd_ones !== 4'd5 || b24.pm !== 1'b1) begin errors++;
      $display("FAIL disp17: bcd=%0d%0d pm=%0d expected 05 pm=1", b24.bcd_tens, b24.bcd_ones, b24.pm); end
    reset = 1'b1;
    #2;
    checks++; if (b24.count !== 5'd0 || b24.carry !== 1'b0 || b24.pm !== 1'b0) begin errors++;
      $display("FAIL async_rst: count=%0d carry=%0d pm=%0d expected 0/0/0", b24.count, b24.carry, b24.pm); end
    reset = 1'b0;
    clk1();
    checks++; if (b24.bcd_tens !== 4'd1 || b24.bcd_ones !== 4'd2 || b24.pm !== 1'b0 || b24.carry !== 1'b0) begin errors++;
      $display("FAIL rst_disp: bcd=%0d%0d pm=%0d carry=%0d expected 12 pm=0 carry=0",
        b24.bcd_tens, b24.bcd_ones, b24.pm, b24.carry); end
    b24.mode_ampm = 1'b0;
  endtask

  task automatic test_wrap60();
    b60.tick = 1'b1;
    repeat (59) clk1();
    checks++; if (b60.count !== 6'd59 || b60.carry !== 1'b0) begin errors++;
      $display("FAIL tick59: count=%0d carry=%0d expected 59/0", b60.count, b60.carry); end
    checks++; if (b60.bcd_tens !== 4'd5 || b60.bcd_ones !== 4'd8) begin errors++;
      $display("FAIL bcd_lag: bcd=%0d%0d expected 58", b60.bcd_tens, b60.bcd_ones); end
    clk1();
    checks++; if (b60.count !== 6'd0 || b60.carry !== 1'b1) begin errors++;
      $display("FAIL wrap60: count=%0d carry=%0d expected 0/1", b60.count, b60.carry); end
    clk1();
    checks++; if (b60.count !== 6'd1 || b60.carry !== 1'b0) begin errors++;
      $display("FAIL after_wrap: count=%0d carry=%0d expected 1/0", b60.count, b60.carry); end
    b60.tick = 1'b0;
    clk1();
    checks++; if (b60.count !== 6'd1 || b60.carry !== 1'b0) begin errors++;
      $display("FAIL idle60: count=%0d carry=%0d expected 1/0", b60.count, b60.carry); end
  endtask

  task automatic test_set_mode();
    int nb;
    int nc;
    load24(0);
    b24.set = 1'b1;
    b24.down_btn = 1'b1;
    nb = 0;
    repeat (6) begin clk1(); if (b24.borrow === 1'b1) nb++; end
    b24.down_btn = 1'b0;
    repeat (4) begin clk1(); if (b24.borrow === 1'b1) nb++; end
    checks++; if (b24.count !== 5'd23) begin errors++;
      $display("FAIL down_wrap: count=%0d expected 23", b24.count); end
    checks++; if (nb != 1) begin errors++;
      $display("FAIL borrow_pulses: got %0d expected 1", nb); end
    b24.up_btn = 1'b1;
    b24.tick = 1'b1;
    nc = 0;
    repeat (RD + 3*RR + 4) begin clk1(); if (b24.carry === 1'b1) nc++; end
    b24.up_btn = 1'b0;
    repeat (6) begin clk1(); if (b24.carry === 1'b1) nc++; end
    b24.tick = 1'b0;
    checks++; if (b24.count !== 5'd4) begin errors++;
      $display("FAIL auto_repeat: count=%0d expected 4 (23 plus 5 steps)", b24.count); end
    checks++; if (nc != 0) begin errors++;
      $display("FAIL set_carry: carry pulses=%0d expected 0", nc); end
    b24.set = 1'b0;
  endtask

  task automatic test_min_value();
    load12(11);
    b12.tick = 1'b1;
    clk1();
    checks++; if (b12.count !== 4'd12 || b12.carry !== 1'b0) begin errors++;
      $display("FAIL tick11: count=%0d carry=%0d expected 12/0", b12.count, b12.carry); end
    clk1();
    b12.tick = 1'b0;
    checks++; if (b12.count !== 4'd1 || b12.carry !== 1'b1) begin errors++;
      $display("FAIL wrap12: count=%0d carry=%0d expected 1/1", b12.count, b12.carry); end
    load12(5);
    load12(0);
    checks++; if (b12.count !== 4'd1) begin errors++;
      $display("FAIL load_below: count=%0d expected 1", b12.count); end
    load12(5);
    load12(13);
    checks++; if (b12.count !== 4'd1) begin errors++;
      $display("FAIL load_above: count=%0d expected 1", b12.count); end
    load12(3);
    b12.set = 1'b1;
    b12.up_btn = 1'b1;
    repeat (3) clk1();
    load12(7);
    checks++; if (b12.count !== 4'd7) begin errors++;
      $display("FAIL load_vs_step: count=%0d expected 7", b12.count); end
    clk1();
    checks++; if (b12.count !== 4'd7) begin errors++;
      $display("FAIL step_dropped: count=%0d expected 7", b12.count); end
    b12.up_btn = 1'b0;
    repeat (4) clk1();
    b12.set = 1'b0;
  endtask

  task automatic test_ampm();
    int vals[5]  = '{0, 11, 12, 13, 23};
    int etens[5] = '{1, 1, 1, 0, 1};
    int eones[5] = '{2, 1, 2, 1, 1};
    int epm[5]   = '{0, 0, 1, 1, 1};
    b24.mode_ampm = 1'b1;
    for (int i = 0; i < 5; i++) begin
      load24(vals[i]);
      clk1();
      checks++;
      if (b24.bcd_tens !== 4'(etens[i]) || b24.bcd_ones !== 4'(eones[i]) || b24.pm !== 1'(epm[i])) begin
        errors++;
        $display("FAIL ampm_%0d: bcd=%0d%0d pm=%0d expected %0d%0d pm=%0d", vals[i],
          b24.bcd_tens, b24.bcd_ones, b24.pm, etens[i], eones[i], epm[i]);
      end
    end
    b24.mode_ampm = 1'b0;
    clk1();
    checks++; if (b24.bcd_tens !== 4'd2 || b24.bcd_ones !== 4'd3 || b24.pm !== 1'b0) begin errors++;
      $display("FAIL mode24: bcd=%0d%0d pm=%0d expected 23 pm=0", b24.bcd_tens, b24.bcd_ones, b24.pm); end
  endtask

  task automatic test_buttons();
    load24(10);
    b24.set = 1'b1;
    b24.up_btn = 1'b1;
    b24.down_btn = 1'b1;
    repeat (8) clk1();
    b24.up_btn = 1'b0;
    b24.down_btn = 1'b0;
    repeat (4) clk1();
    checks++; if (b24.count !== 5'd10) begin errors++;
      $display("FAIL both_btn: count=%0d expected 10", b24.count); end
    b24.up_btn = 1'b1;
    repeat (6) clk1();
    checks++; if (b24.count !== 5'd11) begin errors++;
      $display("FAIL press_up: count=%0d expected 11", b24.count); end
    b24.set = 1'b0;
    repeat (30) clk1();
    checks++; if (b24.count !== 5'd11) begin errors++;
      $display("FAIL run_hold: count=%0d expected 11", b24.count); end
    b24.set = 1'b1;
    repeat (30) clk1();
    checks++; if (b24.count !== 5'd11) begin errors++;
      $display("FAIL reenter_held: count=%0d expected 11", b24.count); end
    b24.up_btn = 1'b0;
    repeat (4) clk1();
    b24.up_btn = 1'b1;
    repeat (6) clk1();
    checks++; if (b24.count !== 5'd12) begin errors++;
      $display("FAIL repress: count=%0d expected 12", b24.count); end
    b24.up_btn = 1'b0;
    b24.set = 1'b0;
    repeat (4) clk1();
  endtask

  initial begin
    b24.tick = 0; b24.set = 0; b24.up_btn = 0; b24.down_btn = 0;
    b24.load = 0; b24.load_value = '0; b24.mode_ampm = 0;
    b60.tick = 0; b60.set = 0; b60.up_btn = 0; b60.down_btn = 0;
    b60.load = 0; b60.load_value = '0; b60.mode_ampm = 0;
    b12.tick = 0; b12.set = 0; b12.up_btn = 0; b12.down_btn = 0;
    b12.load = 0; b12.load_value = '0; b12.mode_ampm = 0;
    test_reset();
    test_wrap60();
    test_set_mode();
    test_min_value();
    test_ampm();
    test_buttons();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
